alu_seq_ctrl: RTL and testbench

Board-level sequencer for the ALU on the Basys 3. The operator loads A, then B, then the opcode through one shared switch bank and a single "next" button.
The block synchronises and debounces the button, and steps a 4-state FSM that captures each value into the ALU operand/opcode registers. It then drives the LEDs with the ALU result.
It sits between the board I/O (switches, button, LEDs) and the combinational alu module.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/btn_debounce_edge.sv | 47 ++++
 rtl/alu_seq_ctrl.sv | 81 ++++++++
 tb/tb_alu_seq_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU board sequencer: opcode encodings and FSM states.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OP   = 2'd2,
    S_SHOW = 2'd3
  } seq_state_t;

endpackage

// File: rtl/btn_debounce_edge.sv
// Push-button conditioner: 2-flop synchroniser, stable-level debouncer and
// a one-cycle strobe on each rising edge of the debounced level.
module btn_debounce_edge #(
  parameter int DB_CNT = 1000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a level change only after DB_CNT differing cycles.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      o_pulse <= 1'b0;
    end else begin
      sync1   <= i_btn;
      sync2   <= sync1;
      level_d <= level;
      o_pulse <= level & ~level_d;
      if (sync2 != level) begin
        if (cnt == CW'(DB_CNT - 1)) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Board sequencer: loads A, B and opcode from the switches on successive
// debounced "next" presses, then shows the ALU result on the LEDs.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int N_SW       = 16,
  parameter int N_OPERANDS = 8,
  parameter int N_OP       = 6,
  parameter int DB_CNT     = 1000000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [N_SW-1:0]       i_sw,
  input  logic                  i_btn_next,
  input  logic [N_OPERANDS-1:0] i_alu_Result,
  output logic [N_OPERANDS-1:0] o_alu_A,
  output logic [N_OPERANDS-1:0] o_alu_B,
  output logic [N_OP-1:0]       o_alu_Op,
  output logic [1:0]            o_state,
  output logic                  o_valid,
  output logic                  o_next_pulse,
  output logic [N_SW-1:0]       o_led
);

  seq_state_t      state;
  seq_state_t      state_next;
  logic            cap_a;
  logic            cap_b;
  logic            cap_op;
  logic [N_SW-1:0] sw_s1;
  logic [N_SW-1:0] sw_s2;

  btn_debounce_edge #(.DB_CNT(DB_CNT)) u_btn (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_btn   (i_btn_next),
    .o_pulse (o_next_pulse)
  );

  // Advance one step per debounced press and flag which register captures.
  always_comb begin
    state_next = state;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    cap_op     = 1'b0;
    if (o_next_pulse) begin
      case (state)
        S_A:     begin cap_a  = 1'b1; state_next = S_B;    end
        S_B:     begin cap_b  = 1'b1; state_next = S_OP;   end
        S_OP:    begin cap_op = 1'b1; state_next = S_SHOW; end
        default: state_next = S_A;
      endcase
    end
  end

  // State, switch synchroniser, operand captures and registered LED/valid drive.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_A;
      sw_s1    <= '0;
      sw_s2    <= '0;
      o_alu_A  <= '0;
      o_alu_B  <= '0;
      o_alu_Op <= '0;
      o_valid  <= 1'b0;
      o_led    <= '0;
    end else begin
      state   <= state_next;
      sw_s1   <= i_sw;
      sw_s2   <= sw_s1;
      o_valid <= (state_next == S_SHOW);
      if (cap_a)  o_alu_A  <= sw_s2[N_OPERANDS-1:0];
      if (cap_b)  o_alu_B  <= sw_s2[N_OPERANDS-1:0];
      if (cap_op) o_alu_Op <= sw_s2[N_OP-1:0];
      o_led <= (state == S_SHOW) ? N_SW'(i_alu_Result) : sw_s2;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed + randomized bench for alu_seq_ctrl with a behavioural ALU and
// sequence model.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  localparam int N_SW = 16;
  localparam int N_OPERANDS = 8;
  localparam int N_OP = 6;
  localparam int DB_CNT = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [N_SW-1:0]       sw = '0;
  logic                  btn = 1'b0;
  logic [N_OPERANDS-1:0] alu_res;
  logic [N_OPERANDS-1:0] alu_a;
  logic [N_OPERANDS-1:0] alu_b;
  logic [N_OP-1:0]       alu_op;
  logic [1:0]            state;
  logic                  valid;
  logic                  next_pulse;
  logic [N_SW-1:0]       led;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;

  int               m_pos = 0;
  logic [7:0]       m_a = '0;
  logic [7:0]       m_b = '0;
  logic [5:0]       m_op = '0;
  logic [N_SW-1:0]  m_sw = '0;

  logic [5:0] op_list [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};

  alu_seq_ctrl #(.N_SW(N_SW), .N_OPERANDS(N_OPERANDS), .N_OP(N_OP), .DB_CNT(DB_CNT)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_sw         (sw),
    .i_btn_next   (btn),
    .i_alu_Result (alu_res),
    .o_alu_A      (alu_a),
    .o_alu_B      (alu_b),
    .o_alu_Op     (alu_op),
    .o_state      (state),
    .o_valid      (valid),
    .o_next_pulse (next_pulse),
    .o_led        (led)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return 8'($signed(a) >>> b);
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign alu_res = alu_ref(alu_a, alu_b, alu_op);

  always @(negedge clk) if (next_pulse) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One clean press/release with the switches held at v; updates the model.
  task automatic press(input logic [N_SW-1:0] v);
    @(negedge clk);
    sw = v;
    cycles(3);
    btn = 1'b1;
    cycles(12);
    btn = 1'b0;
    cycles(12);
    case (m_pos)
      0: m_a  = v[7:0];
      1: m_b  = v[7:0];
      2: m_op = v[5:0];
      default: ;
    endcase
    m_pos = (m_pos + 1) % 4;
    m_sw = v;
  endtask

  task automatic check_all(input string tag);
    logic [N_SW-1:0] exp_led;
    exp_led = (m_pos == 3) ? N_SW'(alu_ref(m_a, m_b, m_op)) : m_sw;
    check({tag, "_A"}, 32'(alu_a), 32'(m_a));
    check({tag, "_B"}, 32'(alu_b), 32'(m_b));
    check({tag, "_Op"}, 32'(alu_op), 32'(m_op));
    check({tag, "_state"}, 32'(state), 32'(m_pos));
    check({tag, "_valid"}, 32'(valid), 32'(m_pos == 3));
    check({tag, "_led"}, 32'(led), 32'(exp_led));
  endtask

  initial begin
    int p0;
    int lat;
    logic [N_SW-1:0] v;

    // Reset
    rst = 1'b1;
    cycles(3);
    #2 check_all("reset");
    check("reset_pulse", 32'(next_pulse), 0);
    rst = 1'b0;
    p0 = pulse_cnt;
    cycles(20);
    check("idle_no_pulse", 32'(pulse_cnt - p0), 0);

    // Full ADD sequence
    press(16'h0005);
    press(16'h00FD);
    press(16'h0020);
    check_all("add");
    check("add_led_const", 32'(led), 32'h0002);

    // Wrap back to S_A; operands retained, LEDs echo switches
    press(16'h1234);
    check_all("wrap");

    // Held button: one pulse, DB_CNT+2 edges after the first high sample
    @(negedge clk);
    sw = 16'h007F;
    cycles(3);
    p0 = pulse_cnt;
    btn = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (next_pulse && lat == 0) lat = k;
    end
    check("held_latency", 32'(lat), 32'(DB_CNT + 3));
    cycles(30);
    btn = 1'b0;
    cycles(12);
    check("held_one_pulse", 32'(pulse_cnt - p0), 1);
    m_a = 8'h7F; m_pos = 1; m_sw = 16'h007F;
    check_all("held");

    // Bounce: short highs never reach the debounced level
    p0 = pulse_cnt;
    for (int i = 0; i < 2; i++) begin
      btn = 1'b1; cycles(2);
      btn = 1'b0; cycles(2);
    end
    cycles(12);
    check("bounce_no_pulse", 32'(pulse_cnt - p0), 0);
    check_all("bounce");

    // Reset mid-sequence clears everything, asynchronously
    #3 rst = 1'b1;
    #1;
    check("midrst_A", 32'(alu_a), 0);
    check("midrst_state", 32'(state), 0);
    cycles(2);
    rst = 1'b0;
    m_pos = 0; m_a = '0; m_b = '0; m_op = '0; m_sw = '0;
    cycles(2);
    check_all("midrst");

    // Randomized full sequences with wrap
    for (int it = 0; it < 6; it++) begin
      v = 16'($urandom);
      press(v);
      v = 16'($urandom);
      press(v);
      v = 16'($urandom);
      v[5:0] = op_list[$urandom_range(0, 7)];
      press(v);
      check_all($sformatf("rnd%0d_show", it));
      v = 16'($urandom);
      press(v);
      check_all($sformatf("rnd%0d_wrap", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
